// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result stream and a FIFO-buffered
// memory/multiply result stream onto the register file's single write port.
// The ALU wins by default; a starvation counter forces the FIFO head through after
// STARVE_LIMIT consecutive ALU wins while buffered results are waiting.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_addr,
  input  logic [35:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_addr,
  input  logic [35:0]              mem_data,
  output logic [35:0]              write_data,
  output logic [4:0]               write_addr,
  output logic                     write_enable,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int SW_MIN = $clog2(STARVE_LIMIT + 1);
  localparam int SW     = (SW_MIN > 3) ? SW_MIN : 3;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // FIFO storage; contents are never reset, only the pointers/count are
  logic [4:0]    r_fifo_addr [DEPTH];
  logic [35:0]   r_fifo_data [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_we;
  logic [4:0]    r_waddr;
  logic [35:0]   r_wdata;

  logic          w_empty;
  logic          w_force;
  logic          w_push;
  logic          w_grant_alu;
  logic          w_grant_fifo;
  logic [4:0]    w_head_addr;
  logic [35:0]   w_head_data;
  logic [4:0]    w_grant_addr;
  logic [35:0]   w_grant_data;
  logic [SW-1:0] w_starve_next;

  assign w_empty     = (r_count == '0);
  assign w_force     = !w_empty && (r_starve == STARVE_MAX);
  assign mem_ready   = (r_count != FULL_COUNT);
  assign w_push      = mem_valid && mem_ready;
  assign alu_ready   = !w_force;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Per-entry storage write: only the slot under the write pointer captures a push
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_fifo_addr[gi] <= mem_addr;
          r_fifo_data[gi] <= mem_data;
        end
      end
    end
  endgenerate

  // Grant selection and starvation-counter next value
  always_comb begin
    w_grant_alu   = 1'b0;
    w_grant_fifo  = 1'b0;
    w_grant_addr  = alu_addr;
    w_grant_data  = alu_data;
    w_starve_next = r_starve;
    if (w_force) begin
      w_grant_fifo = 1'b1;
    end else if (alu_valid) begin
      w_grant_alu = 1'b1;
    end else if (!w_empty) begin
      w_grant_fifo = 1'b1;
    end
    if (w_grant_fifo) begin
      w_grant_addr = w_head_addr;
      w_grant_data = w_head_data;
    end
    if (w_grant_fifo || w_empty) begin
      w_starve_next = '0;
    end else if (w_grant_alu && (r_starve != STARVE_MAX)) begin
      w_starve_next = r_starve + SW'(1);
    end
  end

  // FIFO pointers and occupancy; a full FIFO refuses pushes even while popping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_grant_fifo) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_grant_fifo})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_next;
    end
  end

  // Register-file write port; r0 writes are consumed but never enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_grant_alu || w_grant_fifo) begin
      r_we    <= (w_grant_addr != 5'd0);
      r_waddr <= w_grant_addr;
      r_wdata <= w_grant_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign write_enable = r_we;
  assign write_addr   = r_waddr;
  assign write_data   = r_wdata;
  assign fifo_count   = r_count;
  assign busy         = (r_count != '0) || r_we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a reference model and a write scoreboard.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int SL    = 3;

  typedef struct packed {
    logic [4:0]  a;
    logic [35:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [35:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [35:0] mem_data;
  logic [35:0] write_data;
  logic [4:0]  write_addr;
  logic        write_enable;
  logic [2:0]  fifo_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  wr_t         mq[$];
  wr_t         exp_q[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [35:0] m_data;
  logic        last_push;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .write_data(write_data), .write_addr(write_addr), .write_enable(write_enable),
    .fifo_count(fifo_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  // One clock: called at posedge+1, pre-checks before the edge, post-checks after it
  task automatic tick();
    logic nonempty, force_, galu, gfifo, push;
    wr_t  g, in_alu, in_mem;
    #2;
    nonempty = (mq.size() != 0);
    force_   = nonempty && (m_starve == SL);
    chk("alu_ready", alu_ready, !force_);
    chk("mem_ready", mem_ready, mq.size() != DEPTH);
    galu   = !force_ && alu_valid;
    gfifo  = force_ || (!alu_valid && nonempty);
    push   = mem_valid && (mq.size() != DEPTH);
    in_alu = {alu_addr, alu_data};
    in_mem = {mem_addr, mem_data};
    @(posedge clk);
    #1;
    g = in_alu;
    if (gfifo) g = mq.pop_front();
    if (push) mq.push_back(in_mem);
    last_push = push;
    if (gfifo || !nonempty) m_starve = 0;
    else if (galu && m_starve < SL) m_starve = m_starve + 1;
    if (galu || gfifo) begin
      m_we   = (g.a != 5'd0);
      m_addr = g.a;
      m_data = g.d;
      if (g.a != 5'd0) exp_q.push_back(g);
    end else begin
      m_we = 1'b0;
    end
    chk("write_enable", write_enable, m_we);
    chk("write_addr", write_addr, m_addr);
    chk("write_data", write_data, m_data);
    chk("fifo_count", fifo_count, mq.size());
    chk("busy", busy, (mq.size() != 0) || m_we);
    if (write_enable === 1'b1) begin
      chk("sb_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        g = exp_q.pop_front();
        chk("sb_addr", write_addr, g.a);
        chk("sb_data", write_data, g.d);
      end
    end
    $display("cyc alu_v=%0b mem_v=%0b we=%0b waddr=%0d wdata=%0h cnt=%0d",
             alu_valid, mem_valid, write_enable, write_addr, write_data, fifo_count);
  endtask

  initial begin
    logic [4:0]  ma;
    logic [4:0]  la;
    logic [35:0] ld;
    rst = 1'b0; alu_valid = 0; alu_addr = '0; alu_data = '0;
    mem_valid = 0; mem_addr = '0; mem_data = '0;
    model_reset();

    // power-up reset, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst0_we", write_enable, 1'b0);
    chk("rst0_cnt", fifo_count, 3'd0);
    chk("rst0_mem_ready", mem_ready, 1'b1);
    chk("rst0_addr", write_addr, 5'd0);
    chk("rst0_data", write_data, 36'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU only
    alu_valid = 1; alu_addr = 5'd5; alu_data = 36'h9_1234_5678;
    tick();
    chk("alu_we", write_enable, 1'b1);
    chk("alu_addr", write_addr, 5'd5);
    chk("alu_data", write_data, 36'h9_1234_5678);
    alu_addr = 5'd0; alu_data = 36'h0_DEAD_BEEF;
    tick();
    chk("alu_r0_we", write_enable, 1'b0);
    alu_valid = 0;
    tick();

    // memory only, empty FIFO
    mem_valid = 1; mem_addr = 5'd7; mem_data = 36'hF_0000_0001;
    tick();
    chk("mem_cnt1", fifo_count, 3'd1);
    chk("mem_we_early", write_enable, 1'b0);
    mem_valid = 0;
    tick();
    chk("mem_cnt0", fifo_count, 3'd0);
    chk("mem_we", write_enable, 1'b1);
    chk("mem_addr", write_addr, 5'd7);
    chk("mem_data", write_data, 36'hF_0000_0001);
    tick();

    // fill/full with ALU always valid: forced grant after 3 ALU wins
    ma = 5'd1;
    mem_valid = 1; alu_valid = 1;
    for (int i = 0; i < 14; i++) begin
      mem_addr = ma;
      mem_data = {ma[3:0], 32'($urandom)};
      alu_addr = 5'(16 + (i % 8));
      alu_data = {4'h3, 32'($urandom)};
      tick();
      if (last_push) ma = ma + 5'd1;
      if (i == 3) begin
        chk("full_cnt", fifo_count, 3'd4);
        chk("full_mem_ready", mem_ready, 1'b0);
      end
      if (i == 4) begin
        chk("force1_we", write_enable, 1'b1);
        chk("force1_addr", write_addr, 5'd1);
        chk("force1_cnt", fifo_count, 3'd3);
      end
      if (i == 8) chk("force2_addr", write_addr, 5'd2);
    end
    alu_valid = 0; mem_valid = 0;
    for (int k = 0; k < 10 && mq.size() != 0; k++) tick();
    tick();
    chk("drain_empty", fifo_count, 3'd0);

    // wrap-around: 10 pushes, simultaneous push/pop at count 2
    for (int i = 0; i < 10; i++) begin
      mem_valid = 1;
      mem_addr  = 5'(i + 1);
      mem_data  = {4'(i), 32'($urandom)};
      alu_valid = (i < 2);
      alu_addr  = 5'd30;
      alu_data  = 36'h0_0000_00AA;
      tick();
      if (i >= 2) chk("wrap_cnt2", fifo_count, 3'd2);
    end
    mem_valid = 0; alu_valid = 0;
    for (int k = 0; k < 10 && mq.size() != 0; k++) tick();
    tick();
    chk("wrap_empty", fifo_count, 3'd0);

    // idle: outputs hold
    la = m_addr; ld = m_data;
    for (int k = 0; k < 4; k++) tick();
    chk("idle_we", write_enable, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_addr", write_addr, la);
    chk("idle_data", write_data, ld);

    // mid-cycle async reset with two entries buffered
    alu_valid = 1; alu_addr = 5'd3; alu_data = 36'h1_1111_1111;
    mem_valid = 1; mem_addr = 5'd9; mem_data = 36'h2_2222_2222;
    tick();
    mem_addr = 5'd10; mem_data = 36'h3_3333_3333;
    tick();
    chk("pre_rst_cnt", fifo_count, 3'd2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_we", write_enable, 1'b0);
    chk("rst_cnt", fifo_count, 3'd0);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    alu_valid = 0; mem_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("post_rst_we", write_enable, 1'b0);
    chk("post_rst_cnt", fifo_count, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x36 register file.
- Merges results from two producers into the file's single write port (write_data / write_addr / write_enable):
  - the single-cycle ALU path;
  - a multi-cycle memory/multiply path, buffered in a small FIFO.
- ALU has priority. A starvation counter guarantees forward progress for buffered results.

Parameters:
- DEPTH, 4, memory-path FIFO entries (power of 2, 2..16).
- STARVE_LIMIT, 3, consecutive ALU grants, while the FIFO is non-empty, after which the FIFO head is forced through.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- alu_valid  input  1  ALU result present.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_addr  input  5  ALU destination register.
- alu_data  input  36  ALU result.
- mem_valid  input  1  memory-path result present.
- mem_ready  output  1  FIFO can accept.
- mem_addr  input  5  memory-path destination register.
- mem_data  input  36  memory-path result.
- write_data  output  36  to register file.
- write_addr  output  5  to register file.
- write_enable  output  1  to register file.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  FIFO non-empty or write_enable high.

Behaviour:
- Reset (async, rst=1):
  - write_enable=0, write_addr=0, write_data=0.
  - FIFO pointers=0, fifo_count=0, starve counter=0.
  - In-flight FIFO entries are discarded. No write occurs on the first edge after rst deasserts unless a grant happened that cycle.
- FIFO:
  - mem_ready = (fifo_count != DEPTH). This is combinational from registered state only.
  - Push on mem_valid && mem_ready.
  - When full, no push, even if a pop occurs in the same cycle.
  - No bypass: an entry pushed into an empty FIFO is eligible for grant in the next cycle.
  - Simultaneous push and pop: count unchanged, pointers both advance, wrap mod DEPTH.
- Arbitration (combinational, one grant per cycle). Let force = (fifo non-empty) && (starve == STARVE_LIMIT).
  - force=1: grant FIFO head; alu_ready=0.
  - Else alu_valid=1: grant ALU; alu_ready=1.
  - Else FIFO non-empty: grant FIFO head (pop).
  - Else: no grant.
  - alu_ready = !force, independent of alu_valid.
- Starve counter (3-bit minimum, saturates at STARVE_LIMIT):
  - +1 when the ALU is granted while the FIFO is non-empty.
  - Cleared when the FIFO is granted or the FIFO is empty.
- Output register:
  - On a grant, write_enable <= (granted addr != 0); write_addr/write_data <= granted addr/data.
  - No grant: write_enable <= 0; write_addr and write_data hold their values.
  - Writes to r0 are consumed (popped / alu_ready) but never asserted to the file.
- Latency:
  - ALU: accept at edge N, write_enable high during cycle N+1.
  - Memory path, empty FIFO, no contention: push at edge N, grant in cycle N+1, write_enable high during cycle N+2.
- Ordering:
  - Memory results retire in FIFO order.
  - No ordering is enforced between ALU and memory results. Hazard control upstream owns same-register WAW.
- busy = (fifo_count != 0) || write_enable.

Test Plan:
- Reset check:
  - Stimulus: assert rst mid-cycle with 2 FIFO entries.
  - Required: outputs drop immediately (async) to write_enable=0, fifo_count=0, mem_ready=1. After release, no stale writes appear.
- ALU only:
  - Stimulus: alu_valid, addr=5, data=36'h9_1234_5678.
  - Required: next cycle write_enable=1, write_addr=5, write_data=36'h912345678. Then alu_addr=0 gives alu_ready=1 and write_enable=0.
- Memory only:
  - Stimulus: push addr=7, data=36'hF_0000_0001 into an empty FIFO.
  - Required: write_enable=1, write_addr=7 exactly 2 cycles after the push edge. fifo_count goes 1 then 0.
- Fill/full:
  - Stimulus: mem_valid continuously with alu_valid held high; DEPTH=4, STARVE_LIMIT=3.
  - Required:
    - mem_ready=0 once fifo_count=4.
    - The FIFO head is forced out after 3 ALU grants; alu_ready=0 in that cycle.
    - Starve counter then clears.
    - Order of memory addrs retired = order pushed.
- Wrap-around:
  - Stimulus: 10 pushes interleaved with pops, push and pop in the same cycle at count=2.
  - Required: count stays 2 across the simultaneous cycle. All 10 entries retire in order with correct data across pointer wrap.
- Idle:
  - Stimulus: no valids.
  - Required: write_enable=0, busy=0, write_addr/write_data hold their last values.
